// File: rtl/ldpc_shift_sched_if.sv
// Purpose : bundles the configuration, control and shift-beat signals of ldpc_shift_sched.
// Latency : n/a (wiring only).
// Backpressure: out_valid/out_ready handshake on the beat stream; master drives controls, slave drives beats.
interface ldpc_shift_sched_if #(
    parameter int data_w   = 8,
    parameter int ROWS     = 4,
    parameter int COLS     = 8,
    parameter int MAX_ITER = 10
);
    localparam int AW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int IW = $clog2(MAX_ITER + 1);

    logic              cfg_we;
    logic [AW-1:0]     cfg_addr;
    logic [data_w-1:0] cfg_data;
    logic              start;
    logic              parity_ok;
    logic              out_ready;
    logic              out_valid;
    logic [data_w-1:0] shift;
    logic [RW-1:0]     row_idx;
    logic [CW-1:0]     col_idx;
    logic              first_col;
    logic              last_col;
    logic [IW-1:0]     iter_cnt;
    logic              busy;
    logic              done;

    // Controller side: configures the table, starts decodes, consumes beats.
    modport master (
        output cfg_we, cfg_addr, cfg_data, start, parity_ok, out_ready,
        input  out_valid, shift, row_idx, col_idx, first_col, last_col,
               iter_cnt, busy, done
    );

    // Scheduler side.
    modport slave (
        input  cfg_we, cfg_addr, cfg_data, start, parity_ok, out_ready,
        output out_valid, shift, row_idx, col_idx, first_col, last_col,
               iter_cnt, busy, done
    );
endinterface

// File: rtl/ldpc_shift_sched.sv
// Purpose : walks the base-matrix shift table layer by layer, issuing one shift per accepted beat, per iteration.
// Latency : first beat one cycle after start; one beat/cycle with out_ready high; one CHECK cycle per iteration.
// Backpressure: all beat outputs are registered and hold while out_valid && !out_ready.
module ldpc_shift_sched #(
    parameter int data_w   = 8,
    parameter int D        = 5,
    parameter int ROWS     = 4,
    parameter int COLS     = 8,
    parameter int MAX_ITER = 10
) (
    input logic                clk,
    input logic                rst_n,
    ldpc_shift_sched_if.slave  bus
);
    localparam int N  = ROWS * COLS;
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int IW = $clog2(MAX_ITER + 1);

    localparam logic [AW:0]       N_ENT      = (AW + 1)'(N);
    localparam logic [RW-1:0]     ROW_LAST   = RW'(ROWS - 1);
    localparam logic [CW-1:0]     COL_LAST   = CW'(COLS - 1);
    localparam logic [IW-1:0]     ITER_LAST  = IW'(MAX_ITER);
    localparam logic [data_w-1:0] NULL_SHIFT = '1;

    // Reject parameter sets the schedule cannot represent.
    if (MAX_ITER < 1 || D < 1 || D > (1 << data_w) - 1) begin : g_bad_param
        $error("ldpc_shift_sched: illegal MAX_ITER or lifting size");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [data_w-1:0] tbl_q [N];
    logic [data_w-1:0] tbl_d [N];
    logic              vld_q, vld_d;
    logic [data_w-1:0] shift_q, shift_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic              first_q, first_d;
    logic              last_q, last_d;
    logic [IW-1:0]     iter_q, iter_d;
    logic              done_q, done_d;
    logic              load;

    function automatic logic [AW-1:0] tbl_idx(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return AW'(int'(r) * COLS + int'(c));
    endfunction

    // Table write port: only open while idle; out-of-range addresses dropped.
    always_comb begin
        tbl_d = tbl_q;
        if (state_q == IDLE && bus.cfg_we && {1'b0, bus.cfg_addr} < N_ENT) begin
            tbl_d[bus.cfg_addr] = bus.cfg_data;
        end
    end

    // Walk state machine; the next beat is looked up from tbl_d so a write
    // landing together with start is already visible to beat 0.
    always_comb begin
        state_d = state_q;
        vld_d   = vld_q;
        shift_d = shift_q;
        row_d   = row_q;
        col_d   = col_q;
        first_d = first_q;
        last_d  = last_q;
        iter_d  = iter_q;
        done_d  = 1'b0;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    vld_d   = 1'b1;
                    row_d   = '0;
                    col_d   = '0;
                    iter_d  = IW'(1);
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (vld_q && bus.out_ready) begin
                    if (row_q == ROW_LAST && col_q == COL_LAST) begin
                        state_d = CHECK;
                        vld_d   = 1'b0;
                    end else begin
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            row_d = row_q + RW'(1);
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                        load = 1'b1;
                    end
                end
            end
            CHECK: begin
                if (bus.parity_ok || iter_q == ITER_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = RUN;
                    vld_d   = 1'b1;
                    row_d   = '0;
                    col_d   = '0;
                    iter_d  = iter_q + IW'(1);
                    load    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
            end
        endcase

        if (load) begin
            shift_d = tbl_d[tbl_idx(row_d, col_d)];
            first_d = (col_d == '0);
            last_d  = (col_d == COL_LAST);
        end
    end

    // Shift table register file; reset fills every block with the null code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                tbl_q[i] <= NULL_SHIFT;
            end
        end else begin
            tbl_q <= tbl_d;
        end
    end

    // Control state and registered beat outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
            shift_q <= NULL_SHIFT;
            row_q   <= '0;
            col_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            iter_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            shift_q <= shift_d;
            row_q   <= row_d;
            col_q   <= col_d;
            first_q <= first_d;
            last_q  <= last_d;
            iter_q  <= iter_d;
            done_q  <= done_d;
        end
    end

    assign bus.out_valid = vld_q;
    assign bus.shift     = shift_q;
    assign bus.row_idx   = row_q;
    assign bus.col_idx   = col_q;
    assign bus.first_col = first_q;
    assign bus.last_col  = last_q;
    assign bus.iter_cnt  = iter_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
endmodule

// File: tb/tb_ldpc_shift_sched.sv
// Purpose : directed and randomized stimulus for ldpc_shift_sched against a table/loop reference model.
// Latency : n/a (testbench).
// Backpressure: out_ready driven fixed, 1-0-0-1 pattern, or random per test step.
module tb_ldpc_shift_sched;
    localparam int DW = 8;
    localparam int DD = 5;
    localparam int R  = 4;
    localparam int C  = 8;
    localparam int MI = 10;
    localparam int N  = R * C;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] mdl_tbl [N];

    ldpc_shift_sched_if #(.data_w(DW), .ROWS(R), .COLS(C), .MAX_ITER(MI)) bus ();

    ldpc_shift_sched #(.data_w(DW), .D(DD), .ROWS(R), .COLS(C), .MAX_ITER(MI)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_valid"}, bus.out_valid, 0);
        chk({pfx, "_shift"}, bus.shift, 8'hFF);
        chk({pfx, "_row"},   bus.row_idx, 0);
        chk({pfx, "_col"},   bus.col_idx, 0);
        chk({pfx, "_first"}, bus.first_col, 0);
        chk({pfx, "_last"},  bus.last_col, 0);
        chk({pfx, "_iter"},  bus.iter_cnt, 0);
        chk({pfx, "_busy"},  bus.busy, 0);
        chk({pfx, "_done"},  bus.done, 0);
    endtask

    task automatic write_cfg(input int addr, input logic [7:0] data);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 5'(addr);
        bus.cfg_data = data;
        cyc();
        bus.cfg_we = 1'b0;
        mdl_tbl[addr] = data;
    endtask

    // One complete decode. pass_iter: iteration whose CHECK sees parity_ok=1
    // (0 = never). rmode: 0 ready high, 1 pattern 1,0,0,1, 2 random.
    task automatic run_decode(input int pass_iter, input int rmode, input bit cfg_with_start,
                              input int cws_addr, input logic [7:0] cws_data, input bit noise);
        int   exp_iters;
        int   iter;
        int   b;
        int   cycles;
        int   beats;
        int   budget;
        bit   finished;
        bit   rdy;
        logic [3:0] pat;
        exp_iters = (pass_iter >= 1 && pass_iter <= MI) ? pass_iter : MI;
        iter = 1; b = 0; cycles = 0; beats = 0; finished = 0;
        pat = 4'b1001;
        budget = exp_iters * (N + 1) * ((rmode == 0) ? 1 : 6) + 20;

        bus.start = 1'b1;
        if (cfg_with_start) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_addr = 5'(cws_addr);
            bus.cfg_data = cws_data;
            mdl_tbl[cws_addr] = cws_data;
        end
        cyc();
        bus.start  = 1'b0;
        bus.cfg_we = 1'b0;

        while (!finished && cycles < budget) begin
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = pat[cycles % 4];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.out_ready = rdy;
            bus.start     = 1'b0;
            bus.cfg_we    = 1'b0;
            if (b < N) begin
                bus.parity_ok = 1'($urandom_range(0, 1));
                if (noise) begin
                    bus.start    = ($urandom_range(0, 3) == 0);
                    bus.cfg_we   = ($urandom_range(0, 3) == 0);
                    bus.cfg_addr = 5'($urandom_range(0, N - 1));
                    bus.cfg_data = 8'($urandom);
                    if (iter == 1 && b == 3) begin
                        bus.cfg_we   = 1'b1;
                        bus.cfg_addr = 5'd3;
                        bus.cfg_data = 8'd2;
                    end
                end
                chk("beat_valid", bus.out_valid, 1);
                chk("beat_shift", bus.shift, mdl_tbl[b]);
                chk("beat_row",   bus.row_idx, b / C);
                chk("beat_col",   bus.col_idx, b % C);
                chk("beat_first", bus.first_col, (b % C) == 0);
                chk("beat_last",  bus.last_col, (b % C) == C - 1);
                chk("beat_iter",  bus.iter_cnt, iter);
                chk("beat_busy",  bus.busy, 1);
                chk("beat_done",  bus.done, 0);
                if (rdy) begin
                    b++;
                    beats++;
                end
            end else begin
                bus.parity_ok = (iter == pass_iter);
                chk("check_valid", bus.out_valid, 0);
                chk("check_busy",  bus.busy, 1);
                chk("check_iter",  bus.iter_cnt, iter);
                if (rmode == 0) chk("check_cycle", cycles, iter * (N + 1) - 1);
                if (iter == pass_iter || iter == MI) finished = 1;
                else begin
                    iter++;
                    b = 0;
                end
            end
            cyc();
            cycles++;
        end
        bus.start     = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.parity_ok = 1'b0;

        chk("decode_finished", finished, 1);
        chk("beat_total",      beats, exp_iters * N);
        chk("done_pulse",      bus.done, 1);
        chk("done_busy",       bus.busy, 0);
        chk("done_valid",      bus.out_valid, 0);
        chk("done_iter",       bus.iter_cnt, exp_iters);
        cyc();
        chk("done_clear",      bus.done, 0);
        chk("iter_hold",       bus.iter_cnt, exp_iters);
    endtask

    initial begin
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;
        bus.start     = 1'b0;
        bus.parity_ok = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < N; i++) mdl_tbl[i] = 8'hFF;

        // Reset state, held across edges.
        cyc();
        cyc();
        chk_reset_vals("rst");
        rst_n = 1'b1;
        cyc();
        chk("idle_busy", bus.busy, 0);

        // Table i%D, parity passes first iteration, ready always high.
        for (int i = 0; i < N; i++) write_cfg(i, 8'(i % DD));
        run_decode(1, 0, 0, 0, 8'h00, 0);

        // Parity never passes: full MAX_ITER iterations.
        run_decode(0, 0, 0, 0, 8'h00, 0);

        // 1,0,0,1 ready pattern; writes and start pulses during RUN ignored.
        run_decode(2, 1, 0, 0, 8'h00, 1);

        // Write index 3 together with start: beat 3 carries the new value.
        run_decode(1, 2, 1, 3, 8'd2, 1);

        // Write index 0 together with start: beat 0 carries the new value.
        run_decode(2, 2, 1, 0, 8'd4, 0);

        // Null block at (2,4).
        write_cfg(2 * C + 4, 8'hFF);
        run_decode(1, 0, 0, 0, 8'h00, 0);

        // Random table with occasional nulls, random pass iteration.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 5) write_cfg(i, 8'hFF);
                else write_cfg(i, 8'($urandom_range(0, DD - 1)));
            end
            run_decode(int'($urandom_range(1, 4)), 2, 0, 0, 8'h00, 1);
        end

        // Reset asserted at beat 5 of iteration 2.
        bus.out_ready = 1'b1;
        bus.parity_ok = 1'b0;
        bus.start     = 1'b1;
        cyc();
        bus.start = 1'b0;
        for (int k = 0; k < N + 1 + 5; k++) cyc();
        chk("pre_rst_col",  bus.col_idx, 5);
        chk("pre_rst_iter", bus.iter_cnt, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        for (int i = 0; i < N; i++) mdl_tbl[i] = 8'hFF;
        cyc();
        chk_reset_vals("rst_hold");
        rst_n = 1'b1;
        cyc();
        chk("post_rst_done", bus.done, 0);
        chk("post_rst_busy", bus.busy, 0);

        // Table must read back all-null after the reset.
        run_decode(1, 0, 0, 0, 8'h00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ldpc_shift_sched.md
Name: ldpc_shift_sched

Overview:
- Schedules the cyclic shifter in the layered LDPC decoder.
- Walks the base matrix row by row (layer by layer) and, within a row, column by column, issuing one shift value per accepted beat.
- Repeats the walk per decoding iteration until the parity check passes or the iteration limit is reached.
- The base-matrix shift table is held in a local register file, configured through a write port while idle.

Parameters:
data_w, 8, width of a shift value; all-ones marks a null (zero) block
D, 5, lifting size; legal non-null shifts are 0..D-1
ROWS, 4, base-matrix rows (layers)
COLS, 8, base-matrix columns
MAX_ITER, 10, maximum decoding iterations (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  table write strobe; ignored unless state==IDLE
cfg_addr  in  clog2(ROWS*COLS)  table index = row*COLS+col; out-of-range writes ignored
cfg_data  in  data_w  shift value to store
start  in  1  start-decode pulse; honoured only in IDLE
parity_ok  in  1  syndrome-all-zero flag, sampled in CHECK
out_ready  in  1  downstream shifter/memory stage accepts beat
out_valid  out  1  beat valid
shift  out  data_w  shift for current block (all-ones = null)
row_idx  out  clog2(ROWS)  current layer
col_idx  out  clog2(COLS)  current column
first_col  out  1  col_idx==0 (layer start)
last_col  out  1  col_idx==COLS-1 (layer end)
iter_cnt  out  clog2(MAX_ITER+1)  iterations started in this decode
busy  out  1  state!=IDLE
done  out  1  one-cycle pulse at decode completion

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all table entries all-ones; out_valid=0; shift=all-ones; row_idx=col_idx=0; first_col=last_col=0; iter_cnt=0; busy=0; done=0. Reset mid-decode aborts immediately; no done pulse.
- States: IDLE, RUN, CHECK.
- IDLE: cfg_we writes table[cfg_addr]<=cfg_data at the clock edge. On start: next cycle RUN, out_valid=1, row=0, col=0, shift=table[0], iter_cnt=1. A start coinciding with cfg_we: the write is performed and start is honoured; the write is visible to beat 0.
- RUN: outputs are registered and must hold stable while out_valid&&!out_ready.
  - On out_valid&&out_ready: advance col. At col==COLS-1, wrap col to 0 and increment row.
  - After accepting beat (ROWS-1, COLS-1): next cycle CHECK, out_valid=0.
  - Each new beat presents shift=table[row*COLS+col] with first_col/last_col decoded from the new col.
  - Throughput: 1 beat/cycle with out_ready held high; ROWS*COLS beats per iteration.
- CHECK (one cycle, out_valid=0):
  - If parity_ok=1 or iter_cnt==MAX_ITER: next cycle IDLE, with done=1 for exactly that cycle.
  - Otherwise: iter_cnt+1, row=col=0, next cycle RUN with beat 0.
- iter_cnt holds its final value in IDLE until the next start.
- start, cfg_we and parity_ok are ignored outside the states noted above.
- Null entries are issued as ordinary beats; the shifter itself handles the all-ones code.
- The table stores values verbatim, with no range check. Values D..2^data_w-2 are a configuration error.

Test Plan:
- Reset mid-RUN (beat 5 of iteration 2) -> all outputs at reset values asynchronously, table all-ones, no done pulse, busy=0.
- Load table[i]=i%D (D=5, ROWS=4, COLS=8), start, out_ready=1, parity_ok=1 -> beats 0..31 in consecutive cycles, shift sequence 0,1,2,3,4,0,…, first_col at cols 0, last_col at col 7. CHECK at cycle 33, done pulse at cycle 34 with iter_cnt=1.
- parity_ok=0 always, MAX_ITER=10 -> exactly 320 accepted beats, iter_cnt steps 1..10, done once with iter_cnt=10.
- Toggle out_ready as a 1,0,0,1 pattern -> shift, row_idx and col_idx stable during stalls, no beat skipped or duplicated, 32 accepted beats per iteration.
- cfg_we during RUN targeting index 3 with value 2 -> table unchanged; the next iteration still issues the original table[3]. The same write issued in IDLE the same cycle as start -> beat 3 carries 2.
- Entry with all-ones (null) at (2,4) -> beat 20 shift=8'hFF with out_valid=1. start pulsed during RUN -> ignored, iter_cnt unaffected.
